act_lut_interp: RTL and testbench

ACT_LUT_INTERP -- requirements
Module: act_lut_interp

---
 rtl/act_lut_interp_pkg.sv | 24 ++
 rtl/act_lut16.sv | 28 ++
 rtl/act_lut_interp.sv | 115 +++++++++++
 tb/tb_act_lut_interp.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/act_lut_interp_pkg.sv
// Shared activation constants and the fixed activation LUT contents.
package act_lut_interp_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_FRAC_W = 8;
    localparam int DEF_OUT_W  = 8;
    localparam int LUT_DEPTH  = 16;
    localparam int LUT_ADDR_W = $clog2(LUT_DEPTH);
    localparam int LUT_W      = 8;

    // Table entry for a two's-complement segment index (8..15 are the negative segments).
    function automatic logic signed [LUT_W-1:0] lut_entry(input logic [LUT_ADDR_W-1:0] idx);
        case (idx)
            4'd0:    return 8'sd0;
            4'd1:    return 8'sd12;
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7:
                     return 8'sd15;
            4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14:
                     return -8'sd15;
            default: return -8'sd12;
        endcase
    endfunction

endpackage

// File: rtl/act_lut16.sv
// Combinational 16-entry activation LUT returning the segment base and the
// following segment value used as the interpolation end point.
module act_lut16
    import act_lut_interp_pkg::*;
#(
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic [LUT_ADDR_W-1:0]  addr,
    output logic signed [OUT_W-1:0] base,
    output logic signed [OUT_W-1:0] next
);

    localparam logic [LUT_ADDR_W-1:0] ADDR_NEG_LAST = '1;
    localparam logic [LUT_ADDR_W-1:0] ADDR_POS_END  = {1'b0, {(LUT_ADDR_W-1){1'b1}}};

    // Segment -1 interpolates toward segment 0; the most positive segment clamps to itself.
    always_comb begin
        base = OUT_W'(lut_entry(addr));
        if (addr == ADDR_NEG_LAST) begin
            next = OUT_W'(lut_entry('0));
        end else if (addr == ADDR_POS_END) begin
            next = base;
        end else begin
            next = OUT_W'(lut_entry(addr + LUT_ADDR_W'(1)));
        end
    end

endmodule

// File: rtl/act_lut_interp.sv
// Three-stage piecewise-linear activation: address/fraction register, LUT
// register, interpolated output register, with a single stall enable.
module act_lut_interp
    import act_lut_interp_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int OUT_W  = DEF_OUT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W+FRAC_W-1:0] in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_last,
    output logic [15:0]              out_count
);

    localparam int PROD_W = OUT_W + FRAC_W + 1;

    logic                     en;
    logic [ADDR_W-1:0]        a1;
    logic [FRAC_W-1:0]        f1;
    logic                     l1;
    logic                     v1;
    logic signed [OUT_W-1:0]  lut_base;
    logic signed [OUT_W-1:0]  lut_next;
    logic signed [OUT_W-1:0]  b2;
    logic signed [OUT_W-1:0]  n2;
    logic [FRAC_W-1:0]        f2;
    logic                     l2;
    logic                     v2;
    logic signed [OUT_W:0]    diff;
    logic signed [PROD_W-1:0] prod;
    logic signed [OUT_W-1:0]  result;

    // Reset is folded into the enable so the input side stays ready while
    // the pipeline is being cleared, even if the output was stalled.
    assign en       = out_ready | ~out_valid | rst;
    assign in_ready = en;

    act_lut16 #(
        .OUT_W (OUT_W)
    ) u_lut (
        .addr (a1),
        .base (lut_base),
        .next (lut_next)
    );

    // Stage 1: capture segment address, fraction and framing.
    always_ff @(posedge clk) begin
        if (rst) begin
            a1 <= '0;
            f1 <= '0;
            l1 <= 1'b0;
            v1 <= 1'b0;
        end else if (en) begin
            a1 <= in_data[ADDR_W+FRAC_W-1:FRAC_W];
            f1 <= in_data[FRAC_W-1:0];
            l1 <= in_last;
            v1 <= in_valid;
        end
    end

    // Stage 2: capture the two LUT end points for the segment.
    always_ff @(posedge clk) begin
        if (rst) begin
            b2 <= '0;
            n2 <= '0;
            f2 <= '0;
            l2 <= 1'b0;
            v2 <= 1'b0;
        end else if (en) begin
            b2 <= lut_base;
            n2 <= lut_next;
            f2 <= f1;
            l2 <= l1;
            v2 <= v1;
        end
    end

    // Linear interpolation; the arithmetic shift floors toward -inf.
    always_comb begin
        diff   = (OUT_W+1)'(n2) - (OUT_W+1)'(b2);
        prod   = PROD_W'(diff) * PROD_W'($signed({1'b0, f2}));
        result = OUT_W'(b2 + (prod >>> FRAC_W));
    end

    // Output register: holds its value whenever the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (en) begin
            out_data  <= result;
            out_last  <= l2;
            out_valid <= v2;
        end
    end

    // Emitted-sample counter, cleared after the last sample of a layer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_count <= '0;
        end else if (out_valid && out_ready) begin
            out_count <= out_last ? '0 : out_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_act_lut_interp.sv
// Scoreboard bench for act_lut_interp: drivers push expected results,
// an independent monitor pops and compares on every presented output.
module tb_act_lut_interp;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [11:0]        in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic signed [7:0]  out_data;
    logic               out_last;
    logic [15:0]        out_count;

    typedef struct packed {
        logic signed [7:0] data;
        logic              last;
    } exp_t;

    typedef struct {
        logic [11:0] din;
        int          res;
    } vec_t;

    exp_t        sb[$];
    logic [15:0] exp_cnt = '0;
    int          total = 0;
    int          bad = 0;

    // Hand-computed: base + floor((next-base)*f/256)
    vec_t vecs[16] = '{
        '{12'h080,   6}, '{12'hF80,  -6}, '{12'h7FF,  15}, '{12'hE80, -14},
        '{12'h800, -15}, '{12'h040,   3}, '{12'h0FF,  11}, '{12'h1FF,  14},
        '{12'hF40,  -9}, '{12'hFFF,  -1}, '{12'h100,  12}, '{12'hEFF, -13},
        '{12'h300,  15}, '{12'hC55, -15}, '{12'h700,  15}, '{12'hF01, -12}
    };

    act_lut_interp #(
        .ADDR_W (4),
        .FRAC_W (8),
        .OUT_W  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    // Offer one sample and push its expected result once it is accepted.
    task automatic send(input logic [11:0] d, input logic l, input int res);
        int   tries = 0;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        #1;
        while (!in_ready) begin
            if (tries >= 50) begin
                total++;
                bad++;
                $display("FAIL send_timeout: in_ready stuck at 0 for data %03h", d);
                return;
            end
            tries++;
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        e.data = res[7:0];
        e.last = l;
        sb.push_back(e);
    endtask

    task automatic send_timed(input logic [11:0] d, input int res);
        send(d, 1'b0, res);
        #1 in_valid = 1'b0;
        chk("lat_edge0", int'(out_valid), 0);
        @(posedge clk); #1;
        chk("lat_edge1", int'(out_valid), 0);
        @(posedge clk); #1;
        chk("lat_edge2", int'(out_valid), 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        #3;
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic stream(input bit stall);
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    send(vecs[i].din, (i == 15), vecs[i].res);
                end
                #1 in_valid = 1'b0;
            end
            begin
                if (stall) begin
                    repeat (4) @(negedge clk);
                    out_ready = 1'b0;
                    for (int k = 0; k < 5; k++) begin
                        #1;
                        chk("stall_in_ready", int'(in_ready), 0);
                        @(negedge clk);
                    end
                    out_ready = 1'b1;
                end else begin
                    int w = 0;
                    @(posedge clk); #1;
                    while (!out_valid && w < 10) begin
                        @(posedge clk); #1;
                        w++;
                    end
                    chk("consec_first", int'(out_valid), 1);
                    for (int k = 1; k < 16; k++) begin
                        @(posedge clk); #1;
                        chk("consec_valid", int'(out_valid), 1);
                    end
                    @(posedge clk); #1;
                    chk("consec_end", int'(out_valid), 0);
                end
            end
        join
        drain();
        chk("count_after_last", int'(out_count), 0);
    endtask

    // Monitor: while output is presented it must match the queue head;
    // the head is retired only on an actual transfer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got data %0d with empty scoreboard", out_data);
                end else begin
                    e = sb[0];
                    chk("out_data", int'(out_data), int'(e.data));
                    chk("out_last", int'(out_last), int'(e.last));
                    chk("out_count", int'(out_count), int'(exp_cnt));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        exp_cnt = e.last ? 16'd0 : exp_cnt + 16'd1;
                    end
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_out_count", int'(out_count), 0);
        @(negedge clk);
        rst = 1'b0;

        send_timed(12'h080, 6);
        drain();

        for (int i = 1; i < 5; i++) begin
            send(vecs[i].din, 1'b0, vecs[i].res);
            #1 in_valid = 1'b0;
            drain();
        end

        stream(1'b0);
        stream(1'b1);

        // Reset with samples in flight and the output stalled.
        send(12'h1FF, 1'b0, 14);
        send(12'hF40, 1'b0, -9);
        send(12'h0FF, 1'b0, 11);
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 12'h100;
        sb.delete();
        exp_cnt   = '0;
        #1;
        chk("midrst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_count", int'(out_count), 0);
        chk("midrst_out_last", int'(out_last), 0);
        repeat (4) @(negedge clk);
        #1;
        chk("midrst_no_leak", int'(out_valid), 0);
        send_timed(12'hF80, -6);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
